// File: rtl/emesh_arb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : emesh_arb_pkg
// Purpose  : Shared definitions for the two-input emesh arbiter: output-slot
//            FSM encoding, transaction-counter width and a saturating
//            increment helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package emesh_arb_pkg;

   // Output slot occupancy: EMPTY means a new packet can always be taken
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Width of the per-requester accepted-transaction counters
   localparam int CNT_W = 16;

   // Counter ceiling; counters stick here instead of wrapping
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Increment that holds at CNT_MAX
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end
      return v + 1'b1;
   endfunction

endpackage : emesh_arb_pkg
`default_nettype wire

// File: rtl/emesh_arb2_sel.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : emesh_arb2_sel
// Purpose  : Combinational grant select for two requesters. A lone requester
//            always wins. On a tie the winner depends on the build:
//              EMESH_ARB2_RR_EN defined   -> round robin against last_gnt
//              EMESH_ARB2_RR_EN undefined -> requester 0 has fixed priority
//            gnt is one-hot, or zero when nobody requests.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module emesh_arb2_sel (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   // Pick the winner from the current request pattern
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01: gnt = 2'b01;
         2'b10: gnt = 2'b10;
         2'b11: begin
`ifdef EMESH_ARB2_RR_EN
            // last_gnt names the previous winner; give the tie to the other one
            gnt = last_gnt ? 2'b01 : 2'b10;
`else
            gnt = 2'b01;
`endif
         end
         default: gnt = 2'b00;
      endcase
   end

`ifndef EMESH_ARB2_RR_EN
   // Fixed priority ignores history; keep the port so both builds share a pinout
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt;
`endif

endmodule : emesh_arb2_sel
`default_nettype wire

// File: rtl/emesh_arb2.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : emesh_arb2
// Purpose  : Two-requester emesh arbiter feeding a single shared emaxi wr/rd
//            path through a one-entry output slot. Sustains one packet per
//            cycle when the downstream path does not stall. Keeps saturating
//            per-requester accepted-transaction counters.
// Config   : EMESH_ARB2_RR_EN - round-robin tie break (default: requester 0
//            has fixed priority).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module emesh_arb2
   import emesh_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int PW = 2*AW+40
) (
   input  logic             clk,
   input  logic             reset,
   // requester 0
   input  logic             access_in0,
   input  logic [PW-1:0]    packet_in0,
   output logic             wait_out0,
   // requester 1
   input  logic             access_in1,
   input  logic [PW-1:0]    packet_in1,
   output logic             wait_out1,
   // shared downstream path
   output logic             access_out,
   output logic [PW-1:0]    packet_out,
   input  logic             wait_in,
   // accepted-transaction counters
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   state_t            state;
   state_t            state_nxt;
   logic              last_gnt;
   logic              ready;
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              accept;
   logic              xfer0;
   logic              xfer1;
   logic [PW-1:0]     packet_q;
   logic [CNT_W-1:0]  cnt0_q;
   logic [CNT_W-1:0]  cnt1_q;

   // Slot can take a packet when empty, or when its occupant leaves this cycle
   assign ready = (state == EMPTY) | ~wait_in;

   assign req = {access_in1, access_in0};

   emesh_arb2_sel u_sel (
      .req      (req),
      .last_gnt (last_gnt),
      .gnt      (gnt)
   );

   // A transfer in needs a winner and a ready slot; nothing is taken in reset
   assign accept = ready & (|gnt) & ~reset;
   assign xfer0  = accept & gnt[0];
   assign xfer1  = accept & gnt[1];

   // Only a requester that lost arbitration is held off by the grant term;
   // an idle requester sees backpressure purely from slot readiness.
   assign wait_out0 = reset | ~ready | (access_in0 & ~gnt[0]);
   assign wait_out1 = reset | ~ready | (access_in1 & ~gnt[1]);

   // Slot state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Slot next-state: fill on accept, drain only when nothing replaces it
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (!accept && !wait_in) begin
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   assign access_out = (state == FULL);

   // Capture the winning packet; hold it otherwise (including during stalls)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         packet_q <= '0;
      end else if (accept) begin
         packet_q <= gnt[1] ? packet_in1 : packet_in0;
      end
   end

   assign packet_out = packet_q;

   // Remember the most recent winner; reset value lets requester 0 take the first tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt <= 1'b1;
      end else if (accept) begin
         last_gnt <= gnt[1];
      end
   end

   // Saturating counters of accepted transfers per requester
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (xfer0) begin
            cnt0_q <= sat_inc(cnt0_q);
         end
         if (xfer1) begin
            cnt1_q <= sat_inc(cnt1_q);
         end
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;

endmodule : emesh_arb2
`default_nettype wire
